// File: rtl/cus19_pkg.sv
// cus19_pkg: shared encodings for the custom-19 single-cycle CPU.
//   - Instruction class codes (instr[2:0])
//   - R-type ALU function codes (instr[6:3])
//   - J-type function codes (instr[4:3])
//   - Bit positions of every instruction field
// Optional feature macro: CUS19_ALU_MUL_EN (enables the MUL function code).
package cus19_pkg;

  typedef enum logic [2:0] {
    CLS_R     = 3'b000,
    CLS_LOAD  = 3'b001,
    CLS_J     = 3'b010,
    CLS_STORE = 3'b011
  } cls_e;

  typedef enum logic [3:0] {
    FN_ADD = 4'b0000,
    FN_SUB = 4'b0001,
    FN_MUL = 4'b0010,
    FN_AND = 4'b0011,
    FN_OR  = 4'b0100,
    FN_XOR = 4'b0101,
    FN_SHL = 4'b0110,
    FN_SHR = 4'b0111
  } funct_e;

  typedef enum logic [1:0] {
    JF_JUMP = 2'b00,
    JF_CALL = 2'b01,
    JF_RET  = 2'b10,
    JF_NOP  = 2'b11
  } jf_e;

  // Instruction field bit positions
  localparam int CLS_LSB = 0;
  localparam int CLS_MSB = 2;
  localparam int RD_LSB  = 15;
  localparam int RD_MSB  = 18;
  localparam int RS1_LSB = 11;
  localparam int RS1_MSB = 14;
  localparam int RS2_LSB = 7;
  localparam int RS2_MSB = 10;
  localparam int FN_LSB  = 3;
  localparam int FN_MSB  = 6;
  localparam int IMM_LSB = 3;
  localparam int IMM_MSB = 10;
  localparam int JA_LSB  = 5;
  localparam int JA_MSB  = 15;
  localparam int JF_LSB  = 3;
  localparam int JF_MSB  = 4;

  // Data memory address width (imm8 + base byte, modulo 256)
  localparam int DM_AW = 8;

endpackage

// File: rtl/cus19_if.sv
// cus19_if: command bus between the CPU datapath and the call/return stack.
// Ports (signals):
//   push, push_data : push a return address
//   pop             : discard the top entry
//   pop_data        : current top entry (0 when empty)
//   full, empty     : stack occupancy flags
// Handshake: push and pop are single-cycle commands sampled on the rising
// clock edge. full acts as the inverse ready for push and empty as the
// inverse ready for pop; a command issued while its ready is low is
// ignored by the stack, so the master may rely on that instead of gating.
interface cus19_if #(
  parameter int PC_W = 11
);
  logic            push;
  logic            pop;
  logic [PC_W-1:0] push_data;
  logic [PC_W-1:0] pop_data;
  logic            full;
  logic            empty;

  modport master (output push, pop, push_data, input pop_data, full, empty);
  modport slave  (input push, pop, push_data, output pop_data, full, empty);
endinterface

// File: rtl/cus19_call_stack.sv
// cus19_call_stack: hardware return-address stack for CALL/RETURN.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset (empties the stack)
//   stk     : cus19_if slave (push/pop commands, top data, full/empty)
// Entries themselves are not reset; only the stack pointer is.
module cus19_call_stack
  import cus19_pkg::*;
#(
  parameter int PC_Width    = 11,
  parameter int Stack_Depth = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  cus19_if.slave stk
);

  localparam int SP_W  = $clog2(Stack_Depth + 1);
  localparam int IDX_W = (Stack_Depth > 1) ? $clog2(Stack_Depth) : 1;

  logic [PC_Width-1:0] r_entries [Stack_Depth];
  logic [SP_W-1:0]     r_sp;
  logic                w_full;
  logic                w_empty;
  logic                w_do_push;
  logic                w_do_pop;
  logic [IDX_W-1:0]    w_wr_idx;
  logic [IDX_W-1:0]    w_rd_idx;

  assign w_full    = (r_sp == SP_W'(Stack_Depth));
  assign w_empty   = (r_sp == '0);
  assign w_do_push = stk.push && !w_full;
  assign w_do_pop  = stk.pop && !w_empty;
  // r_sp points at the next free slot; the top lives one below it.
  assign w_wr_idx  = IDX_W'(r_sp);
  assign w_rd_idx  = IDX_W'(r_sp - SP_W'(1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sp <= '0;
    end else if (w_do_push) begin
      r_sp <= r_sp + SP_W'(1);
    end else if (w_do_pop) begin
      r_sp <= r_sp - SP_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_entries[w_wr_idx] <= stk.push_data;
    end
  end

  assign stk.pop_data = w_empty ? '0 : r_entries[w_rd_idx];
  assign stk.full     = w_full;
  assign stk.empty    = w_empty;

endmodule

// File: rtl/cus19_mem.sv
// Storage blocks of the custom-19 CPU.
// cus19_imem: instruction memory, combinational read.
//   i_clk, i_we, i_waddr, i_wdata : synchronous load port (tied off in the
//                                   CPU; images are placed directly in mem)
//   i_raddr / o_rdata             : fetch port
// cus19_regfile: register file, two operand reads plus one store-data read,
//   one synchronous write. Register 0 always reads 0 and ignores writes.
module cus19_imem #(
  parameter int AW = 11,
  parameter int DW = 19
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem[i_raddr];
endmodule

module cus19_regfile #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr1,
  input  logic [AW-1:0] i_raddr2,
  input  logic [AW-1:0] i_raddr3,
  output logic [DW-1:0] o_rdata1,
  output logic [DW-1:0] o_rdata2,
  output logic [DW-1:0] o_rdata3
);
  logic [DW-1:0] reg_file [2**AW];

  always_ff @(posedge i_clk) begin
    if (i_we && (i_waddr != '0)) begin
      reg_file[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == '0) ? '0 : reg_file[i_raddr1];
  assign o_rdata2 = (i_raddr2 == '0) ? '0 : reg_file[i_raddr2];
  assign o_rdata3 = (i_raddr3 == '0) ? '0 : reg_file[i_raddr3];
endmodule

// File: rtl/cus19_top_module.sv
// cus19_top_module: single-cycle custom-19 CPU (19-bit instructions, 8-bit data).
// Ports:
//   cus19_clk_in   : clock, rising edge; one instruction retires per edge
//   cus19_rst_in   : asynchronous active-low reset (PC, stack, result outputs)
//   alu_result_out : full 16-bit result of the last R-type instruction
//   ld_result_out  : zero-extended byte of the last LOAD
// Instances: M2 = instruction memory (array mem), M5 = register file
// (array reg_file), u_stack = call/return stack.
// Optional feature macro: CUS19_ALU_MUL_EN enables the multiplier for funct
// 0010; without it that function returns 0 and no multiplier is built.
module cus19_top_module
  import cus19_pkg::*;
#(
  parameter int PC_Width       = 11,
  parameter int Stack_Depth    = 8,
  parameter int Instr_Width    = 19,
  parameter int Data_Width     = 8,
  parameter int Reg_Addr_Width = 4
) (
  input  logic                    cus19_clk_in,
  input  logic                    cus19_rst_in,
  output logic [2*Data_Width-1:0] alu_result_out,
  output logic [2*Data_Width-1:0] ld_result_out
);

  localparam int RW = 2 * Data_Width;

  logic [PC_Width-1:0]    r_pc;
  logic [RW-1:0]          r_alu_result;
  logic [RW-1:0]          r_ld_result;
  logic [Data_Width-1:0]  r_dmem [2**DM_AW];

  logic [Instr_Width-1:0]    w_instr;
  cls_e                      w_cls;
  funct_e                    w_funct;
  jf_e                       w_jf;
  logic [Reg_Addr_Width-1:0] w_rd;
  logic [Reg_Addr_Width-1:0] w_rs1;
  logic [Reg_Addr_Width-1:0] w_rs2;
  logic [DM_AW-1:0]          w_imm;
  logic [PC_Width-1:0]       w_jaddr;
  logic [Data_Width-1:0]     w_rs1_val;
  logic [Data_Width-1:0]     w_rs2_val;
  logic [Data_Width-1:0]     w_rd_val;
  logic [RW-1:0]             w_a;
  logic [RW-1:0]             w_b;
  logic [RW-1:0]             w_alu;
  logic [DM_AW-1:0]          w_mem_addr;
  logic [Data_Width-1:0]     w_dm_rdata;
  logic [PC_Width-1:0]       w_pc_inc;
  logic [PC_Width-1:0]       w_pc_next;
  logic                      w_rf_we;
  logic [Data_Width-1:0]     w_rf_wdata;
  logic                      w_dm_we;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_alu_upd;
  logic                      w_ld_upd;

  cus19_if #(.PC_W(PC_Width)) u_stk_if ();

  // Fetch
  cus19_imem #(.AW(PC_Width), .DW(Instr_Width)) M2 (
    .i_clk   (cus19_clk_in),
    .i_we    (1'b0),
    .i_waddr ('0),
    .i_wdata ('0),
    .i_raddr (r_pc),
    .o_rdata (w_instr)
  );

  // Decode
  assign w_cls   = cls_e'(w_instr[CLS_MSB:CLS_LSB]);
  assign w_funct = funct_e'(w_instr[FN_MSB:FN_LSB]);
  assign w_jf    = jf_e'(w_instr[JF_MSB:JF_LSB]);
  assign w_rd    = w_instr[RD_MSB:RD_LSB];
  assign w_rs1   = w_instr[RS1_MSB:RS1_LSB];
  assign w_rs2   = w_instr[RS2_MSB:RS2_LSB];
  assign w_imm   = w_instr[IMM_MSB:IMM_LSB];
  assign w_jaddr = PC_Width'(w_instr[JA_MSB:JA_LSB]);

  // Register writes are squashed while reset is held so an aborted cycle
  // leaves the register file untouched.
  cus19_regfile #(.AW(Reg_Addr_Width), .DW(Data_Width)) M5 (
    .i_clk    (cus19_clk_in),
    .i_we     (w_rf_we && cus19_rst_in),
    .i_waddr  (w_rd),
    .i_wdata  (w_rf_wdata),
    .i_raddr1 (w_rs1),
    .i_raddr2 (w_rs2),
    .i_raddr3 (w_rd),
    .o_rdata1 (w_rs1_val),
    .o_rdata2 (w_rs2_val),
    .o_rdata3 (w_rd_val)
  );

  cus19_call_stack #(.PC_Width(PC_Width), .Stack_Depth(Stack_Depth)) u_stack (
    .i_clk   (cus19_clk_in),
    .i_rst_n (cus19_rst_in),
    .stk     (u_stk_if.slave)
  );

  assign u_stk_if.push      = w_push;
  assign u_stk_if.pop       = w_pop;
  assign u_stk_if.push_data = w_pc_inc;

  // ALU, evaluated at double width so SUB wraps modulo 2**16 and SHL keeps bit 8
  assign w_a = RW'(w_rs1_val);
  assign w_b = RW'(w_rs2_val);

  always_comb begin
    w_alu = '0;
    case (w_funct)
      FN_ADD: w_alu = w_a + w_b;
      FN_SUB: w_alu = w_a - w_b;
`ifdef CUS19_ALU_MUL_EN
      FN_MUL: w_alu = w_a * w_b;
`else
      FN_MUL: w_alu = '0;
`endif
      FN_AND: w_alu = w_a & w_b;
      FN_OR:  w_alu = w_a | w_b;
      FN_XOR: w_alu = w_a ^ w_b;
      FN_SHL: w_alu = w_a << 1;
      FN_SHR: w_alu = w_a >> 1;
      default: w_alu = '0;
    endcase
  end

  // Data memory address: base register plus imm8, wrapping at 256
  assign w_mem_addr = DM_AW'(w_rs1_val) + w_imm;
  assign w_dm_rdata = r_dmem[w_mem_addr];
  assign w_pc_inc   = r_pc + PC_Width'(1);

  // Next PC and write enables
  always_comb begin
    w_pc_next  = w_pc_inc;
    w_rf_we    = 1'b0;
    w_rf_wdata = '0;
    w_dm_we    = 1'b0;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_alu_upd  = 1'b0;
    w_ld_upd   = 1'b0;
    case (w_cls)
      CLS_R: begin
        w_rf_we    = 1'b1;
        w_rf_wdata = w_alu[Data_Width-1:0];
        w_alu_upd  = 1'b1;
      end
      CLS_LOAD: begin
        w_rf_we    = 1'b1;
        w_rf_wdata = w_dm_rdata;
        w_ld_upd   = 1'b1;
      end
      CLS_STORE: begin
        w_dm_we = 1'b1;
      end
      CLS_J: begin
        case (w_jf)
          JF_JUMP: w_pc_next = w_jaddr;
          JF_CALL: begin
            // A full stack drops the return address: CALL degrades to JUMP.
            w_push    = !u_stk_if.full;
            w_pc_next = w_jaddr;
          end
          JF_RET: begin
            // RETURN on an empty stack falls through as PC+1.
            if (!u_stk_if.empty) begin
              w_pop     = 1'b1;
              w_pc_next = u_stk_if.pop_data;
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge cus19_clk_in or negedge cus19_rst_in) begin
    if (!cus19_rst_in) begin
      r_pc         <= '0;
      r_alu_result <= '0;
      r_ld_result  <= '0;
    end else begin
      r_pc <= w_pc_next;
      if (w_alu_upd) begin
        r_alu_result <= w_alu;
      end
      if (w_ld_upd) begin
        r_ld_result <= RW'(w_dm_rdata);
      end
    end
  end

  always_ff @(posedge cus19_clk_in) begin
    if (w_dm_we && cus19_rst_in) begin
      r_dmem[w_mem_addr] <= w_rd_val;
    end
  end

  assign alu_result_out = r_alu_result;
  assign ld_result_out  = r_ld_result;

endmodule

// File: tb/tb_cus19_top_module.sv
// tb_cus19_top_module: self-checking bench for cus19_top_module.
// A behavioural model (integer arrays and a queue-based stack) executes the
// same program one instruction per clock; each cycle its PC/ALU/LOAD results
// go into an expected queue that is compared against the DUT.
module tb_cus19_top_module;

  localparam int NIMEM = 2048;

  // Clock / reset
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] alu_o;
  logic [15:0] ld_o;

  always #5 clk = ~clk;

  cus19_top_module dut (
    .cus19_clk_in   (clk),
    .cus19_rst_in   (rst_n),
    .alu_result_out (alu_o),
    .ld_result_out  (ld_o)
  );

  // Scoreboard state
  int          n_cmp = 0;
  int          n_err = 0;
  logic [42:0] exp_q[$];
  string       cur_test;

  // Reference model state
  logic [18:0] m_imem [NIMEM];
  int          m_rf [16];
  int          m_dmem [256];
  int          m_stk[$];
  int          m_pc;
  int          m_alu;
  int          m_ld;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s_%s: observed %0h expected %0h", cur_test, tag, obs, exp);
    end
  endtask

  // Instruction encoders
  function automatic logic [18:0] enc_r(input int rd, input int rs1, input int rs2, input int fn);
    return {4'(rd), 4'(rs1), 4'(rs2), 4'(fn), 3'b000};
  endfunction

  function automatic logic [18:0] enc_mem(input int cls, input int rd, input int base, input int imm);
    return {4'(rd), 4'(base), 8'(imm), 3'(cls)};
  endfunction

  function automatic logic [18:0] enc_j(input int addr, input int jf);
    return {3'b000, 11'(addr), 2'(jf), 3'b010};
  endfunction

  // One instruction of the architectural model
  task automatic model_step();
    logic [18:0] ins;
    int cls, rd, rs1, rs2, fn, imm, tgt, jf, a, b, res, addr, nxt;
    ins  = m_imem[m_pc];
    cls  = int'(ins[2:0]);
    rd   = int'(ins[18:15]);
    rs1  = int'(ins[14:11]);
    rs2  = int'(ins[10:7]);
    fn   = int'(ins[6:3]);
    imm  = int'(ins[10:3]);
    tgt  = int'(ins[15:5]);
    jf   = int'(ins[4:3]);
    nxt  = (m_pc + 1) % NIMEM;
    addr = (m_rf[rs1] + imm) % 256;
    if (cls == 0) begin
      a = m_rf[rs1];
      b = m_rf[rs2];
      case (fn)
        0: res = a + b;
        1: res = (a - b + 65536) % 65536;
`ifdef CUS19_ALU_MUL_EN
        2: res = a * b;
`else
        2: res = 0;
`endif
        3: res = a & b;
        4: res = a | b;
        5: res = a ^ b;
        6: res = a * 2;
        7: res = a / 2;
        default: res = 0;
      endcase
      m_alu = res;
      if (rd != 0) m_rf[rd] = res % 256;
    end else if (cls == 1) begin
      m_ld = m_dmem[addr];
      if (rd != 0) m_rf[rd] = m_dmem[addr];
    end else if (cls == 3) begin
      m_dmem[addr] = m_rf[rd];
    end else if (cls == 2) begin
      if (jf == 0) begin
        nxt = tgt;
      end else if (jf == 1) begin
        if (m_stk.size() < 8) m_stk.push_back(nxt);
        nxt = tgt;
      end else if (jf == 2) begin
        if (m_stk.size() > 0) nxt = m_stk.pop_back();
      end
    end
    m_pc = nxt;
    exp_q.push_back({11'(m_pc), 16'(m_alu), 16'(m_ld)});
  endtask

  task automatic clear_model();
    for (int i = 0; i < NIMEM; i++) m_imem[i] = '0;
    for (int i = 0; i < 16; i++) m_rf[i] = 0;
    for (int i = 0; i < 256; i++) m_dmem[i] = 0;
  endtask

  task automatic load_dut();
    for (int i = 0; i < NIMEM; i++) dut.M2.mem[i] <= m_imem[i];
    for (int i = 0; i < 16; i++) dut.M5.reg_file[i] <= 8'(m_rf[i]);
    for (int i = 0; i < 256; i++) dut.r_dmem[i] <= 8'(m_dmem[i]);
  endtask

  // Hold reset across one edge, preload, then release
  task automatic start_test(input string name);
    cur_test = name;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_pc", 32'(dut.r_pc), 32'd0);
    check("rst_alu", 32'(alu_o), 32'd0);
    check("rst_ld", 32'(ld_o), 32'd0);
    load_dut();
    m_pc  = 0;
    m_alu = 0;
    m_ld  = 0;
    m_stk.delete();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Driver: advance n instructions, comparing each one
  task automatic run(input int n);
    logic [42:0] e;
    repeat (n) begin
      @(posedge clk);
      model_step();
      #1;
      e = exp_q.pop_front();
      check("pc", 32'(dut.r_pc), 32'(e[42:32]));
      check("alu", 32'(alu_o), 32'(e[31:16]));
      check("ld", 32'(ld_o), 32'(e[15:0]));
    end
  endtask

  task automatic check_regs();
    for (int i = 1; i < 16; i++) check($sformatf("r%0d", i), 32'(dut.M5.reg_file[i]), 32'(m_rf[i]));
  endtask

  task automatic check_dmem();
    for (int i = 0; i < 256; i++) check($sformatf("dmem%0d", i), 32'(dut.r_dmem[i]), 32'(m_dmem[i]));
  endtask

  task automatic jump_call_program();
    clear_model();
    m_rf[2] = 5;
    m_rf[3] = 10;
    m_imem[0]  = enc_j(5, 0);
    m_imem[5]  = enc_r(4, 2, 3, 0);
    m_imem[6]  = enc_j(10, 1);
    m_imem[7]  = enc_j(0, 2);
    m_imem[10] = enc_r(4, 3, 2, 1);
    m_imem[11] = enc_j(0, 2);
  endtask

  initial begin
    logic [18:0] ins;
    int c;

    // JUMP / CALL / RETURN
    jump_call_program();
    start_test("jcr");
    run(1);
    check("pc_after_jump", 32'(dut.r_pc), 32'd5);
    run(1);
    check("r4_add", 32'(dut.M5.reg_file[4]), 32'd15);
    run(1);
    check("pc_after_call", 32'(dut.r_pc), 32'd10);
    run(2);
    check("pc_after_ret", 32'(dut.r_pc), 32'd7);
    check("r4_sub", 32'(dut.M5.reg_file[4]), 32'd5);
    check("alu_sub", 32'(alu_o), 32'd5);
    check_regs();

    // SUB underflow
    clear_model();
    m_rf[2] = 5;
    m_rf[3] = 10;
    m_imem[0] = enc_r(4, 2, 3, 1);
    start_test("sub_uf");
    run(1);
    check("alu", 32'(alu_o), 32'h0000FFFB);
    check("r4", 32'(dut.M5.reg_file[4]), 32'h000000FB);

    // STORE then LOAD
    clear_model();
    m_rf[1] = 7;
    m_rf[5] = 8'hA5;
    m_imem[0] = enc_mem(3, 5, 1, 3);
    m_imem[1] = enc_mem(1, 6, 1, 3);
    start_test("st_ld");
    run(2);
    check("dmem10", 32'(dut.r_dmem[10]), 32'hA5);
    check("r6", 32'(dut.M5.reg_file[6]), 32'hA5);
    check("ld_out", 32'(ld_o), 32'h00A5);
    check_dmem();

    // Nine nested CALLs then nine RETURNs
    clear_model();
    for (int k = 0; k < 9; k++) m_imem[k * 100] = enc_j((k + 1) * 100, 1);
    for (int k = 0; k < 8; k++) m_imem[k * 100 + 1] = enc_j(0, 2);
    m_imem[900] = enc_j(0, 2);
    start_test("nest");
    run(8);
    check("pc_8th_call", 32'(dut.r_pc), 32'd800);
    run(1);
    check("pc_9th_call", 32'(dut.r_pc), 32'd900);
    run(8);
    check("pc_8th_ret", 32'(dut.r_pc), 32'd1);
    run(1);
    check("pc_9th_ret", 32'(dut.r_pc), 32'd2);

    // MUL (feature-dependent)
    clear_model();
    m_rf[2] = 200;
    m_rf[3] = 3;
    m_rf[4] = 8'h11;
    m_imem[0] = enc_r(4, 2, 3, 2);
    start_test("mul");
    run(1);
`ifdef CUS19_ALU_MUL_EN
    check("alu", 32'(alu_o), 32'd600);
    check("r4", 32'(dut.M5.reg_file[4]), 32'h58);
`else
    check("alu", 32'(alu_o), 32'd0);
    check("r4", 32'(dut.M5.reg_file[4]), 32'd0);
`endif

    // PC wrap, including a CALL at the last address pushing a wrapped return
    clear_model();
    m_imem[0]    = enc_j(2047, 0);
    m_imem[2047] = enc_j(20, 1);
    m_imem[20]   = enc_j(0, 2);
    start_test("wrap");
    run(1);
    check("pc_top", 32'(dut.r_pc), 32'd2047);
    run(2);
    check("pc_wrapped", 32'(dut.r_pc), 32'd0);

    // Reset mid-program: state cleared at once, registers retained, rerun
    jump_call_program();
    start_test("midrst");
    run(3);
    #2;
    rst_n = 1'b0;
    #1;
    check("pc_now", 32'(dut.r_pc), 32'd0);
    check("alu_now", 32'(alu_o), 32'd0);
    check("ld_now", 32'(ld_o), 32'd0);
    m_pc  = 0;
    m_alu = 0;
    m_ld  = 0;
    m_stk.delete();
    @(posedge clk);
    #1;
    check("pc_held", 32'(dut.r_pc), 32'd0);
    check("r4_kept", 32'(dut.M5.reg_file[4]), 32'd15);
    check_regs();
    @(negedge clk);
    rst_n = 1'b1;
    run(6);
    check("pc_rerun", 32'(dut.r_pc), 32'd8);
    check_regs();

    // Randomized programs in a 64-word loop
    for (int t = 0; t < 4; t++) begin
      clear_model();
      for (int i = 1; i < 16; i++) m_rf[i] = $urandom_range(0, 255);
      for (int i = 0; i < 256; i++) m_dmem[i] = $urandom_range(0, 255);
      for (int i = 0; i < 63; i++) begin
        ins = 19'($urandom);
        c = $urandom_range(0, 5);
        case (c)
          0, 1: ins[2:0] = 3'b000;
          2: ins[2:0] = 3'b001;
          3: ins[2:0] = 3'b011;
          4: begin
            ins[2:0]  = 3'b010;
            ins[15:5] = 11'($urandom_range(0, 63));
          end
          default: ins[2:0] = 3'($urandom_range(4, 7));
        endcase
        m_imem[i] = ins;
      end
      m_imem[63] = enc_j(0, 0);
      start_test($sformatf("rand%0d", t));
      run(300);
      check_regs();
      check_dmem();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
